// File: rtl/wb_stage.sv
// Write-back stage: merges pipeline results (ALU / extracted load) and one long-latency result onto the regfile write port.
// Latency: a source accepted in cycle N is presented on regwrite/write1/write_data in cycle N+1 for one cycle.
// Backpressure: pipeline has priority; a blocked long-latency result is forced through after STARVE_MAX cycles, stalling the pipeline.
module wb_stage #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_load_data,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    output logic        regwrite,
    output logic [4:0]  write1,
    output logic [31:0] write_data,
    output logic        retire
);

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  rd;
        logic [31:0] dat;
        logic        retire;
    } wr_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             force_ll;
    logic             in_acc;
    logic             ll_acc;
    logic [1:0]       off;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_val;
    wr_t              wr_nxt;

    assign force_ll = (cnt == CNT_MAX) && ll_valid;

    // Both readies are held low while reset is asserted, independent of the clock.
    always_comb begin
        in_ready = 1'b0;
        ll_ready = 1'b0;
        if (RST_N) begin
            if (force_ll) begin
                ll_ready = 1'b1;
            end else if (in_valid) begin
                in_ready = 1'b1;
            end else begin
                in_ready = 1'b1;
                ll_ready = ll_valid;
            end
        end
    end

    assign in_acc = in_valid && in_ready;
    assign ll_acc = ll_valid && ll_ready;

    assign off     = in_alu_result[1:0];
    assign ld_half = off[1] ? in_load_data[31:16] : in_load_data[15:0];

    always_comb begin
        case (off)
            2'd0:    ld_byte = in_load_data[7:0];
            2'd1:    ld_byte = in_load_data[15:8];
            2'd2:    ld_byte = in_load_data[23:16];
            default: ld_byte = in_load_data[31:24];
        endcase
    end

    always_comb begin
        case (in_funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = in_load_data;
        endcase
    end

    // Address and data hold across idle cycles; only the enable and retire pulse drop.
    always_comb begin
        wr_nxt.regwrite = 1'b0;
        wr_nxt.rd       = write1;
        wr_nxt.dat      = write_data;
        wr_nxt.retire   = 1'b0;
        if (in_acc) begin
            wr_nxt.regwrite = in_regwrite && (in_rd != 5'd0);
            wr_nxt.rd       = in_rd;
            wr_nxt.dat      = in_memtoreg ? ld_val : in_alu_result;
            wr_nxt.retire   = 1'b1;
        end else if (ll_acc) begin
            wr_nxt.regwrite = (ll_rd != 5'd0);
            wr_nxt.rd       = ll_rd;
            wr_nxt.dat      = ll_data;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        if (ll_valid && !ll_ready) begin
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            regwrite   <= 1'b0;
            write1     <= 5'd0;
            write_data <= 32'd0;
            retire     <= 1'b0;
            cnt        <= '0;
        end else begin
            regwrite   <= wr_nxt.regwrite;
            write1     <= wr_nxt.rd;
            write_data <= wr_nxt.dat;
            retire     <= wr_nxt.retire;
            cnt        <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a transaction-level reference model.
module tb_wb_stage;

    localparam int STARVE_MAX = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_load_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        regwrite;
    logic [4:0]  write1;
    logic [31:0] write_data;
    logic        retire;

    always #5 CLK = ~CLK;

    wb_stage #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_regwrite   (in_regwrite),
        .in_memtoreg   (in_memtoreg),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_load_data  (in_load_data),
        .ll_valid      (ll_valid),
        .ll_ready      (ll_ready),
        .ll_rd         (ll_rd),
        .ll_data       (ll_data),
        .regwrite      (regwrite),
        .write1        (write1),
        .write_data    (write_data),
        .retire        (retire)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the write port should show after the next edge.
    logic        m_rw;
    logic [4:0]  m_w1;
    logic [31:0] m_wd;
    logic        m_ret;
    int          m_wait;
    logic        acc_in;
    logic        acc_ll;
    logic        dut_in_rdy;
    logic        dut_ll_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned off;
        logic [31:0] b;
        logic [31:0] h;
        off = addr % 4;
        b   = (word >> (8 * off)) & 32'h0000_00FF;
        h   = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    task automatic model_reset();
        m_rw   = 1'b0;
        m_w1   = 5'd0;
        m_wd   = 32'd0;
        m_ret  = 1'b0;
        m_wait = 0;
    endtask

    task automatic set_idle();
        in_valid      = 1'b0;
        in_rd         = 5'd0;
        in_regwrite   = 1'b0;
        in_memtoreg   = 1'b0;
        in_funct3     = 3'd0;
        in_alu_result = 32'd0;
        in_load_data  = 32'd0;
        ll_valid      = 1'b0;
        ll_rd         = 5'd0;
        ll_data       = 32'd0;
    endtask

    task automatic step();
        logic forced;
        logic e_in_rdy;
        logic e_ll_rdy;
        @(negedge CLK);
        forced   = ll_valid && (m_wait == STARVE_MAX);
        e_in_rdy = !forced;
        e_ll_rdy = forced || (!in_valid && ll_valid);
        dut_in_rdy = in_ready;
        dut_ll_rdy = ll_ready;
        check("in_ready", 32'(in_ready), 32'(e_in_rdy));
        check("ll_ready", 32'(ll_ready), 32'(e_ll_rdy));
        acc_in = in_valid && e_in_rdy;
        acc_ll = ll_valid && e_ll_rdy;
        m_rw  = 1'b0;
        m_ret = 1'b0;
        if (acc_in) begin
            m_rw  = in_regwrite && (in_rd != 5'd0);
            m_w1  = in_rd;
            m_wd  = in_memtoreg ? load_value(in_funct3, in_alu_result, in_load_data) : in_alu_result;
            m_ret = 1'b1;
        end else if (acc_ll) begin
            m_rw = (ll_rd != 5'd0);
            m_w1 = ll_rd;
            m_wd = ll_data;
        end
        if (ll_valid && !e_ll_rdy) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : m_wait;
        else                       m_wait = 0;
        @(posedge CLK);
        #1;
        check("regwrite",   32'(regwrite), 32'(m_rw));
        check("write1",     32'(write1),   32'(m_w1));
        check("write_data", write_data,    m_wd);
        check("retire",     32'(retire),   32'(m_ret));
    endtask

    task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_regwrite   = 1'b1;
        in_memtoreg   = 1'b0;
        in_alu_result = val;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] ld_adr [5] = '{32'h103, 32'h102, 32'h100, 32'h102, 32'h104};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'h0000_80FF, 32'h80FF_7F01};

    initial begin
        set_idle();
        model_reset();
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        #1;
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_write1",   32'(write1),   32'd0);
        check("rst_retire",   32'(retire),   32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ll_ready", 32'(ll_ready), 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;

        alu_write(5'd5, 32'h1234_5678);
        step();
        check("alu_regwrite", 32'(regwrite), 32'd1);
        check("alu_write1",   32'(write1),   32'd5);
        check("alu_data",     write_data,    32'h1234_5678);
        check("alu_retire",   32'(retire),   32'd1);

        in_memtoreg  = 1'b1;
        in_load_data = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            in_funct3     = ld_f3[i];
            in_alu_result = ld_adr[i];
            in_rd         = 5'(10 + i);
            step();
            check($sformatf("load_%0d", i), write_data, ld_exp[i]);
        end

        alu_write(5'd0, 32'hCAFE_0001);
        step();
        check("x0_regwrite", 32'(regwrite), 32'd0);
        check("x0_retire",   32'(retire),   32'd1);

        set_idle();
        ll_valid = 1'b1;
        ll_rd    = 5'd0;
        ll_data  = 32'h5555_AAAA;
        step();
        check("llx0_ready",    32'(dut_ll_rdy), 32'd1);
        check("llx0_regwrite", 32'(regwrite),   32'd0);

        alu_write(5'd2, 32'h0000_0042);
        ll_valid = 1'b1;
        ll_rd    = 5'd9;
        ll_data  = 32'hDEAD_BEEF;
        for (int i = 1; i <= 5; i++) begin
            in_alu_result = 32'(i);
            step();
            check($sformatf("starve_ll_ready_%0d", i), 32'(dut_ll_rdy), (i == 5) ? 32'd1 : 32'd0);
        end
        check("starve_in_ready", 32'(dut_in_rdy), 32'd0);
        check("starve_regwrite", 32'(regwrite),   32'd1);
        check("starve_write1",   32'(write1),     32'd9);
        check("starve_data",     write_data,      32'hDEAD_BEEF);
        ll_valid = 1'b0;
        step();
        ll_valid = 1'b1;
        ll_rd    = 5'd4;
        step();
        check("starve_cnt_clear", 32'(dut_ll_rdy), 32'd0);

        set_idle();
        ll_valid = 1'b1;
        ll_rd    = 5'd3;
        ll_data  = 32'd7;
        step();
        check("ll_idle_ready",  32'(dut_ll_rdy), 32'd1);
        check("ll_idle_write1", 32'(write1),     32'd3);
        check("ll_idle_data",   write_data,      32'd7);
        check("ll_idle_retire", 32'(retire),     32'd0);

        set_idle();
        alu_write(5'd7, 32'h0BAD_F00D);
        step();
        check("mid_regwrite_pre", 32'(regwrite), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mid_regwrite", 32'(regwrite),   32'd0);
        check("mid_data",     write_data,      32'd0);
        check("mid_retire",   32'(retire),     32'd0);
        check("mid_in_ready", 32'(in_ready),   32'd0);
        check("mid_ll_ready", 32'(ll_ready),   32'd0);
        model_reset();
        set_idle();
        @(posedge CLK);
        #2 RST_N = 1'b1;

        for (int n = 0; n < 600; n++) begin
            step();
            if (!(in_valid && !acc_in)) begin
                in_valid      = ($urandom_range(0, 3) != 0);
                in_rd         = 5'($urandom_range(0, 31));
                in_regwrite   = ($urandom_range(0, 4) != 0);
                in_memtoreg   = ($urandom_range(0, 1) != 0);
                in_funct3     = 3'($urandom_range(0, 7));
                in_alu_result = $urandom;
                in_load_data  = $urandom;
            end
            if (!(ll_valid && !acc_ll)) begin
                ll_valid = ($urandom_range(0, 2) == 0);
                ll_rd    = 5'($urandom_range(0, 31));
                ll_data  = $urandom;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
